// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for the pixel core. Produces wrapping horizontal
// and vertical scan counters (default 640x480@60, 800x525 total), the
// undelayed active-area flag, line/frame start strobes, and VGA sync plus
// display-enable outputs. The sync and display-enable outputs pass through
// a PIPE_DELAY-deep delay line so they line up with the core's registered
// pixel output.
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//   defined   -> frame_count is an 8-bit frame counter (mod 256)
//   undefined -> frame_count is tied to zero
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   pix_en      in   pixel-clock enable; all state advances only when high
//   pixel_col   out  [9:0] column counter, 0..H_TOTAL-1 (raw, unsaturated)
//   pixel_row   out  [9:0] row counter, 0..V_TOTAL-1 (raw, unsaturated)
//   active      out  undelayed col<H_ACTIVE && row<V_ACTIVE
//   line_start  out  pix_en && col==0
//   frame_start out  pix_en && col==0 && row==0
//   hsync       out  horizontal sync, active-low, delayed PIPE_DELAY
//   vsync       out  vertical sync, active-low, delayed PIPE_DELAY
//   de          out  display enable (active delayed PIPE_DELAY)
//   frame_count out  [7:0] frame counter (see macro above)
//
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters); PIPE_DELAY
// is legal in the range 0..4.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] pixel_col,
    output logic [9:0] pixel_row,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit constants so a full 1024 boundary is still representable.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  col;
    logic [9:0]  row;
    logic [10:0] col_x;
    logic [10:0] row_x;
    logic        col_wrap;
    logic        row_wrap;
    logic        hs_raw;
    logic        vs_raw;
    logic        act_raw;

    assign col_x = {1'b0, col};
    assign row_x = {1'b0, row};

    always_comb begin
        col_wrap = (col_x == H_LAST);
        row_wrap = (row_x == V_LAST);
        act_raw  = (col_x < H_VIS) && (row_x < V_VIS);
        hs_raw   = !((col_x >= HS_BEGIN) && (col_x < HS_END));
        vs_raw   = !((row_x >= VS_BEGIN) && (row_x < VS_END));
    end

    // Scan counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_en) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    assign pixel_col   = col;
    assign pixel_row   = row;
    assign active      = act_raw;
    assign line_start  = pix_en && (col == '0);
    assign frame_start = pix_en && (col == '0) && (row == '0);

    // Delay line of {hs, vs, de}; reset loads the idle pattern into every
    // stage so no partial sync pulse survives a mid-frame reset.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync = hs_raw;
            assign vsync = vs_raw;
            assign de    = act_raw;
        end else begin : g_delay
            logic [2:0] stage [PIPE_DELAY];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= 3'b110;
                    end
                end else if (pix_en) begin
                    stage[0] <= {hs_raw, vs_raw, act_raw};
                    for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign hsync = stage[PIPE_DELAY-1][2];
            assign vsync = stage[PIPE_DELAY-1][1];
            assign de    = stage[PIPE_DELAY-1][0];
        end
    endgenerate

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frames;

    // Advances on the same edge that takes the counters from the last
    // pixel of the frame back to (0,0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frames <= '0;
        end else if (pix_en && col_wrap && row_wrap) begin
            frames <= frames + 8'd1;
        end
    end

    assign frame_count = frames;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen using a reduced raster (16x8 total)
// so that hundreds of frames fit in a short run. The reference model tracks
// only the number of enabled clock edges since reset and derives every
// expected output from it with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int unsigned HA = 8;
    localparam int unsigned HF = 2;
    localparam int unsigned HS = 3;
    localparam int unsigned HB = 3;
    localparam int unsigned VA = 4;
    localparam int unsigned VF = 1;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 1;
    localparam int unsigned D  = 2;

    localparam int unsigned HT    = HA + HF + HS + HB;
    localparam int unsigned VT    = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [9:0] pixel_col;
    logic [9:0] pixel_row;
    logic       active;
    logic       line_start;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] frame_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Enabled edges since the last reset.
    int unsigned n = 0;

    // Run-length trackers over enabled samples.
    int unsigned hs_low  = 0;
    int unsigned de_seen = 0;

    vga_timing_gen #(
        .H_ACTIVE  (HA),
        .H_FP      (HF),
        .H_SYNC    (HS),
        .H_BP      (HB),
        .V_ACTIVE  (VA),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB),
        .PIPE_DELAY(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .pixel_col  (pixel_col),
        .pixel_row  (pixel_row),
        .active     (active),
        .line_start (line_start),
        .frame_start(frame_start),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic int unsigned col_of(input int unsigned k);
        return k % HT;
    endfunction

    function automatic int unsigned row_of(input int unsigned k);
        return (k / HT) % VT;
    endfunction

    function automatic logic raw_hs(input int unsigned k);
        int unsigned c = col_of(k);
        return !(c >= HA + HF && c < HA + HF + HS);
    endfunction

    function automatic logic raw_vs(input int unsigned k);
        int unsigned r = row_of(k);
        return !(r >= VA + VF && r < VA + VF + VS);
    endfunction

    function automatic logic raw_act(input int unsigned k);
        return (col_of(k) < HA) && (row_of(k) < VA);
    endfunction

    task automatic check_all();
        logic exp_hs;
        logic exp_vs;
        logic exp_de;
        int unsigned exp_fc;
        if (n >= D) begin
            exp_hs = raw_hs(n - D);
            exp_vs = raw_vs(n - D);
            exp_de = raw_act(n - D);
        end else begin
            exp_hs = 1'b1;
            exp_vs = 1'b1;
            exp_de = 1'b0;
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        exp_fc = (n / FRAME) % 256;
`else
        exp_fc = 0;
`endif
        check("col",         32'(pixel_col),   32'(col_of(n)));
        check("row",         32'(pixel_row),   32'(row_of(n)));
        check("active",      32'(active),      32'(raw_act(n)));
        check("line_start",  32'(line_start),  32'(pix_en && col_of(n) == 0));
        check("frame_start", 32'(frame_start), 32'(pix_en && col_of(n) == 0 && row_of(n) == 0));
        check("hsync",       32'(hsync),       32'(exp_hs));
        check("vsync",       32'(vsync),       32'(exp_vs));
        check("de",          32'(de),          32'(exp_de));
        check("frame_count", 32'(frame_count), exp_fc);
    endtask

    // One clock: drive inputs, let the edge happen, update the model,
    // then sample on the falling edge.
    task automatic step(input logic en, input logic rn);
        pix_en = en;
        rst_n  = rn;
        @(posedge clk);
        if (!rn) begin
            n       = 0;
            hs_low  = 0;
            de_seen = 0;
        end else if (en) begin
            n++;
        end
        @(negedge clk);
        check_all();
        if (rn && en) begin
            if (hsync == 1'b0) begin
                hs_low++;
            end else if (hs_low != 0) begin
                check("hsync_width", hs_low, HS);
                hs_low = 0;
            end
            if (de) de_seen++;
            if (n % FRAME == 0) begin
                check("de_per_frame", de_seen, HA * VA);
                de_seen = 0;
            end
        end
    endtask

    initial begin
        int unsigned guard;
        pix_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Continuous enable across 257+ frames (frame counter wraps 255->0).
        for (int i = 0; i < int'(FRAME * 258 + 5); i++) step(1'b1, 1'b1);

        // Alternating enable: every output must hold through disabled clocks.
        for (int i = 0; i < 2 * int'(FRAME) + 17; i++) step(1'(i % 2 == 0), 1'b1);

        // Random enable pattern.
        for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)), 1'b1);

        // Reset asserted while the delayed hsync and vsync are both low.
        guard = 0;
        while (n % FRAME != (VA + VF) * HT + HA + HF + D && guard < 2 * FRAME) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check("reach_sync_point", guard < 2 * FRAME, 1'b1);
        check("pre_reset_hsync", 32'(hsync), 32'(0));
        check("pre_reset_vsync", 32'(vsync), 32'(0));
        step(1'b1, 1'b0);
        check("post_reset_col", 32'(pixel_col), 32'(0));
        check("post_reset_row", 32'(pixel_row), 32'(0));
        check("post_reset_hsync", 32'(hsync), 32'(1));
        check("post_reset_vsync", 32'(vsync), 32'(1));
        check("post_reset_de", 32'(de), 32'(0));
        check("post_reset_fc", 32'(frame_count), 32'(0));

        // Random enable with occasional resets.
        for (int i = 0; i < 4000; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 149) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing stage directly upstream of the pixel core.
- Generates the horizontal and vertical scan counters that drive the core's pixel_row/pixel_col inputs.
- Generates VGA sync and display-enable outputs, delayed to line up with the core's registered pixel output.
- Replaces the free-running, unsaturated row/col counters in the top level with properly wrapping 640x480@60 timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DELAY, 1, pixel-clock stages applied to hsync/vsync/de to match pixel core latency; legal range 0..4

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- pix_en  input  1  pixel-clock enable; counters and delay line advance only when high
- pixel_col  output  10  current column counter, 0..H_TOTAL-1
- pixel_row  output  10  current row counter, 0..V_TOTAL-1
- active  output  1  undelayed: col<H_ACTIVE && row<V_ACTIVE
- line_start  output  1  pix_en && col==0
- frame_start  output  1  pix_en && col==0 && row==0
- hsync  output  1  horizontal sync, active-low, delayed PIPE_DELAY
- vsync  output  1  vertical sync, active-low, delayed PIPE_DELAY
- de  output  1  display enable = active delayed PIPE_DELAY
- frame_count  output  8  frame counter (see Optional Feature)

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
- Reset values:
  - pixel_col=0, pixel_row=0, frame_count=0.
  - All delay-line stages set to hsync=1, vsync=1, de=0.
  - active=1, because the counters sit at (0,0).
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Computed at elaboration; the counters are 10-bit, so both totals must be ≤1024.
- Counting (only on clk edges with pix_en=1):
  - col==H_TOTAL-1 → col<=0, and row advances.
  - Otherwise col<=col+1.
  - Row advance: row==V_TOTAL-1 → row<=0; otherwise row<=row+1.
  - pix_en=0 → all state holds, including the delay line.
- Raw sync, combinational from the counters:
  - hs_raw=0 iff H_ACTIVE+H_FP ≤ col < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw=0 iff V_ACTIVE+V_FP ≤ row < V_ACTIVE+V_FP+V_SYNC (490..491).
- Delay line:
  - PIPE_DELAY-deep shift register of {hs_raw, vs_raw, active}, shifted on pix_en.
  - hsync/vsync/de are the last stage.
  - PIPE_DELAY=0 → outputs are the raw combinational values.
- pixel_col/pixel_row are raw counters and are never saturated; the consumer qualifies them with active/de.
- line_start/frame_start are single-cycle, pix_en-qualified, combinational. frame_start asserts on the first pix_en after reset.
- Reset mid-frame: next cycle is (0,0) with delay line cleared; no partial sync pulse survives.
- Simultaneous col and row wrap at (H_TOTAL-1, V_TOTAL-1): both go to 0 on the same edge; frame_count increments on that same edge.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: frame_count is an 8-bit register.
  - Increments by 1 (mod 256) on the pix_en edge where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Reset to 0. Used for animation and test patterns.
- Undefined: frame_count is tied to 8'd0 and no register is inferred.

Test Plan:
- Reset then pix_en=1 continuous, default params → col runs 0..799 then 0; row increments at each col wrap; row 524→0 after 420000 enabled cycles; frame_start high exactly at cycle 0 and cycle 420000.
- Default params, PIPE_DELAY=1 → hsync low for exactly 96 consecutive enabled cycles per line, going low one enabled cycle after col==656; vsync low for 1600 cycles, going low one cycle after (col 0, row 490).
- pix_en toggled 1,0,1,0… → counters advance once per two clks; hsync/de timing identical when measured in enabled cycles; all outputs stable while pix_en=0.
- de check → high for exactly 640x480=307200 enabled cycles per frame; never high for row≥480 or col≥640 (one-cycle delayed view).
- Assert rst_n=0 for one clk at (col 700, row 491) during hsync/vsync low → next cycle col=0, row=0, hsync=1, vsync=1, de=0; frame_count=0.
- With VGA_TIMING_FRAME_CNT_EN, run 257 full frames → frame_count reads 0,1,…,255,0,1; without the macro frame_count stays 0.
